// File: rtl/fft_prog_delay_line.sv
// fft_prog_delay_line: runtime-programmable single-pointer delay line for the FFT datapath
// Delays in_valid/in_data by cur_delay advances (1..MAX_DELAY), loaded via cfg_load/delay_cfg.
// Ports: clk, rst_n (async, active-low); advance (clock enable); cfg_load, delay_cfg (delay request);
//   in_valid, in_data (input stream); out_valid, out_data (delayed stream); primed (line full);
//   cfg_err (one-cycle pulse on illegal delay_cfg); cur_delay (active delay).
// Optional: define FFT_DL_OUT_REG_EN to register out_data/out_valid (latency becomes D+1 advances).
module fft_prog_delay_line #(
  parameter int WIDTH = 32,
  parameter int MAX_DELAY = 512,
  localparam int AW = $clog2(MAX_DELAY + 1),
  localparam int PW = $clog2(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             cfg_load,
  input  logic [AW-1:0]    delay_cfg,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             primed,
  output logic             cfg_err,
  output logic [AW-1:0]    cur_delay
);
  logic [WIDTH-1:0] mem [MAX_DELAY];
  logic [MAX_DELAY-1:0] vld;
  logic [PW-1:0] ptr;
  logic [AW-1:0] fill;
  logic cfg_ok, load, step;
  assign cfg_ok = delay_cfg != '0 && delay_cfg <= AW'(MAX_DELAY);
  assign load = cfg_load && cfg_ok;
  // A legal load takes priority; the sample offered alongside it is dropped.
  assign step = advance && !load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      fill <= '0;
      vld <= '0;
      cur_delay <= AW'(MAX_DELAY);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (load) begin
        cur_delay <= delay_cfg;
        ptr <= '0;
        fill <= '0;
        vld <= '0;
      end else if (advance) begin
        vld[ptr] <= in_valid;
        ptr <= (AW'(ptr) == cur_delay - 1'b1) ? '0 : ptr + 1'b1;
        fill <= (fill == cur_delay) ? fill : fill + 1'b1;
      end
    end
  // Data storage has no reset; invalid samples leave the slot untouched.
  always_ff @(posedge clk)
    if (step && in_valid) mem[ptr] <= in_data;
`ifdef FFT_DL_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      primed <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b0;
      out_data <= '0;
      primed <= 1'b0;
    end else if (advance) begin
      out_valid <= vld[ptr];
      out_data <= mem[ptr];
      primed <= fill == cur_delay;
    end
`else
  // Read-before-write: the slot under ptr is shown before this advance overwrites it.
  assign out_valid = vld[ptr];
  assign out_data = mem[ptr];
  assign primed = fill == cur_delay;
`endif
endmodule

// File: tb/tb_fft_prog_delay_line.sv
// tb_fft_prog_delay_line: directed bench with a history-queue model for fft_prog_delay_line
module tb_fft_prog_delay_line;
  localparam int W = 32;
  localparam int MD = 8;
  localparam int AW = 4;
  logic clk = 1'b0, rst_n = 1'b1, advance = 1'b0, cfg_load = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] delay_cfg = '0;
  logic [W-1:0] in_data = '0;
  logic out_valid, primed, cfg_err;
  logic [W-1:0] out_data;
  logic [AW-1:0] cur_delay;
  int total = 0, bad = 0;
  bit started = 0;
  bit hv[$];
  logic [W-1:0] hd[$];
  int k = 0, md = MD;
  bit merr = 0;
  fft_prog_delay_line #(.WIDTH(W), .MAX_DELAY(MD)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .cfg_load(cfg_load), .delay_cfg(delay_cfg),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .primed(primed), .cfg_err(cfg_err), .cur_delay(cur_delay)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // Model: every advance since the last flush appends one sample; the output after
  // k advances is the sample appended lat advances earlier.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hv.delete();
      hd.delete();
      k = 0;
      md = MD;
      merr = 0;
    end else begin
      merr = cfg_load && (delay_cfg == 0 || int'(delay_cfg) > MD);
      if (cfg_load && !merr) begin
        md = int'(delay_cfg);
        hv.delete();
        hd.delete();
        k = 0;
      end else if (advance) begin
        hv.push_back(in_valid);
        hd.push_back(in_data);
        k++;
      end
    end
  always @(negedge clk)
    if (started) begin
      int lat;
`ifdef FFT_DL_OUT_REG_EN
      lat = md + 1;
`else
      lat = md;
`endif
      chk("m_cur_delay", 32'(cur_delay), 32'(md));
      chk("m_cfg_err", 32'(cfg_err), 32'(merr));
      chk("m_primed", 32'(primed), 32'(k >= lat));
      if (k >= lat) begin
        chk("m_out_valid", 32'(out_valid), 32'(hv[k-lat]));
        if (hv[k-lat]) chk("m_out_data", out_data, hd[k-lat]);
      end else chk("m_out_valid", 32'(out_valid), 32'd0);
    end
  task automatic step(input bit a, input bit l, input int c, input bit v, input int d);
    advance = a;
    cfg_load = l;
    delay_cfg = AW'(c);
    in_valid = v;
    in_data = W'(d);
    @(posedge clk);
    #1;
  endtask
  task automatic fill_chk();
    for (int i = 0; i < 8; i++) begin
      chk("fill_low", 32'(out_valid), 32'd0);
      step(1, 0, 0, 1, i + 1);
    end
    chk("fill_v8", 32'(out_valid), 32'd1);
    chk("fill_d8", out_data, 32'd1);
    chk("fill_primed", 32'(primed), 32'd1);
    step(1, 0, 0, 1, 9);
    chk("fill_d9", out_data, 32'd2);
    step(1, 0, 0, 1, 10);
  endtask
  initial begin
    bit bv[6];
    bv = '{0, 0, 1, 0, 1, 1};
    #1 rst_n = 1'b0;
    started = 1;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_cur", 32'(cur_delay), 32'd8);
    chk("rst_err", 32'(cfg_err), 32'd0);
    fill_chk();
    step(1, 1, 3, 1, 'hEE);
    chk("rc_cur", 32'(cur_delay), 32'd3);
    chk("rc_low0", 32'(out_valid), 32'd0);
    step(1, 0, 0, 1, 'hA);
    chk("rc_low1", 32'(out_valid), 32'd0);
    step(1, 0, 0, 1, 'hB);
    chk("rc_low2", 32'(out_valid), 32'd0);
    step(1, 0, 0, 1, 'hC);
    chk("rc_a", out_data, 32'hA);
    step(1, 0, 0, 1, 'hD);
    chk("rc_b", out_data, 32'hB);
    step(1, 0, 0, 1, 'hE);
    step(0, 1, 4, 0, 0);
    step(1, 0, 0, 1, 5);
    step(0, 0, 0, 1, 'h66);
    chk("st_hold_v", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1, 'h66);
    step(1, 0, 0, 1, 6);
    step(1, 0, 0, 1, 7);
    step(1, 0, 0, 1, 8);
    chk("st_d5", out_data, 32'd5);
    chk("st_primed", 32'(primed), 32'd1);
    step(1, 0, 0, 1, 9);
    chk("st_d6", out_data, 32'd6);
    step(0, 0, 0, 1, 'h77);
    chk("st_hold1", out_data, 32'd6);
    step(0, 0, 0, 1, 'h77);
    chk("st_hold2", out_data, 32'd6);
    step(1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chk("bub_v", 32'(out_valid), 32'(bv[i]));
      if (i == 2) chk("bub_d2", out_data, 32'h21);
      if (i == 4) chk("bub_d4", out_data, 32'h23);
      if (i == 5) chk("bub_d5", out_data, 32'h24);
      step(1, 0, 0, i < 4 && i != 1, 'h21 + i);
    end
    step(1, 1, 0, 1, 'h30);
    chk("ill_err0", 32'(cfg_err), 32'd1);
    chk("ill_cur0", 32'(cur_delay), 32'd2);
    step(1, 0, 0, 1, 'h31);
    chk("ill_clr0", 32'(cfg_err), 32'd0);
    step(1, 1, 9, 1, 'h32);
    chk("ill_err9", 32'(cfg_err), 32'd1);
    chk("ill_cur9", 32'(cur_delay), 32'd2);
    step(1, 0, 0, 1, 'h33);
    chk("ill_clr9", 32'(cfg_err), 32'd0);
    chk("ill_data", out_data, 32'h32);
    advance = 1'b1;
    in_valid = 1'b1;
    in_data = 'h50;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_primed", 32'(primed), 32'd0);
    chk("ar_cur", 32'(cur_delay), 32'd8);
    #4 rst_n = 1'b1;
    advance = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    fill_chk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
